minimig_zorro_mapper: RTL and testbench

MINIMIG_ZORRO_MAPPER -- requirements
Module: minimig_zorro_mapper

---
 rtl/minimig_zorro_mapper.sv | 170 +++++++++++++++++
 tb/tb_minimig_zorro_mapper.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/minimig_zorro_mapper.sv
// minimig_zorro_mapper
// Snoops the autoconfig register writes the CPU makes and works out where
// the three RAM boards (Zorro II fast RAM, Zorro III board 1, Zorro III
// board 2) land in the address map. It then decodes CPU addresses against
// the committed windows.
//
// Ports
//   clk, reset_n          system clock, async active-low reset
//   clk7_en, sel          7 MHz qualifier and autoconfig region strobe
//   address_in[8:1]       autoconfig register address (byte address >> 1)
//   data_in, hwr, lwr     CPU write data and byte write strobes
//   fastram_config        ZII size: 00 off, 01 2 MB, 10 4 MB, 11 8 MB
//   slowram_config        ZIII board 2 size: nonzero 16 MB, zero 4 MB
//   board_configured[3:0] per-board configured flags (bit 3 unused)
//   cpu_addr[31:20]       CPU address at 1 MB granularity
//   cpu_req               CPU access valid this cycle
//   ram_sel[2:0]          registered one-hot board hit
//   ram_valid             ram_sel qualifier (cpu_req delayed one clock)
//   map_active[2:0]       board i mapping committed (ACTIVE)
module minimig_zorro_mapper #(
  parameter int ZIII0_LOG2 = 24  // board-1 size log2, valid range 20..31
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clk7_en,
  input  logic         sel,
  input  logic [8:1]   address_in,
  input  logic [15:0]  data_in,
  input  logic         hwr,
  input  logic         lwr,
  input  logic [1:0]   fastram_config,
  input  logic [1:0]   slowram_config,
  input  logic [3:0]   board_configured,
  input  logic [31:20] cpu_addr,
  input  logic         cpu_req,
  output logic [2:0]   ram_sel,
  output logic         ram_valid,
  output logic [2:0]   map_active
);

  // Register byte addresses 0x4A/0x48/0x44/0x4C seen on address_in[8:1].
  localparam logic [8:1] AC_Z2_LO = 8'h25;
  localparam logic [8:1] AC_Z2_HI = 8'h24;
  localparam logic [8:1] AC_Z3    = 8'h22;
  localparam logic [8:1] AC_SHUT  = 8'h26;

  // Address bits [31:ZIII0_LOG2] are compared for board 1.
  localparam logic [11:0] Z3B1_MASK = 12'hFFF << (ZIII0_LOG2 - 20);

  typedef enum logic [1:0] {UNCONF, STAGED, ACTIVE, SHUTUP} bstate_e;

  bstate_e         state_q [3];
  bstate_e         state_d [3];
  logic [2:0][7:0] base_q, base_d;   // board 0: A23:16, boards 1/2: A31:24
  logic [2:0]      bc_q;
  logic [2:0]      ram_sel_q, ram_sel_d;
  logic            ram_valid_q;

  logic       snoop, wr_lo, wr_hi, wr_z3, wr_shut;
  logic [2:0] stage, shut, rise, hit, act;
  logic [3:0] z2_mask;
  logic [11:0] z3b2_mask;

  logic unused_ok;
  assign unused_ok = ^{data_in[7:0], board_configured[3]};

  // Write snooping and per-board next state.
  always_comb begin
    snoop   = clk7_en & sel & (hwr | lwr);
    wr_lo   = snoop && (address_in == AC_Z2_LO);
    wr_hi   = snoop && (address_in == AC_Z2_HI);
    wr_z3   = snoop && (address_in == AC_Z3);
    wr_shut = snoop && (address_in == AC_SHUT);

    // Pending board is chosen from the registered flags so a base write
    // landing in the same cycle as that board's configured edge still
    // targets it and the new base is the one committed.
    stage    = '0;
    stage[0] = wr_lo | wr_hi;
    if (wr_z3) begin
      if (!bc_q[1])      stage[1] = 1'b1;
      else if (!bc_q[2]) stage[2] = 1'b1;
    end

    shut = '0;
    if (wr_shut) begin
      if (!bc_q[0])      shut[0] = 1'b1;
      else if (!bc_q[1]) shut[1] = 1'b1;
      else if (!bc_q[2]) shut[2] = 1'b1;
    end

    rise = board_configured[2:0] & ~bc_q;

    base_d = base_q;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      // ACTIVE and SHUTUP boards ignore further writes.
      if (stage[i] && (state_q[i] == UNCONF || state_q[i] == STAGED)) begin
        if (i == 0) begin
          if (wr_lo) base_d[0][3:0] = data_in[15:12];
          if (wr_hi) base_d[0][7:4] = data_in[15:12];
        end else begin
          base_d[i] = data_in[15:8];
        end
      end
      case (state_q[i])
        UNCONF: begin
          if (shut[i])       state_d[i] = SHUTUP;
          else if (rise[i])  state_d[i] = stage[i] ? ACTIVE : SHUTUP;
          else if (stage[i]) state_d[i] = STAGED;
        end
        STAGED: begin
          if (shut[i])      state_d[i] = SHUTUP;
          else if (rise[i]) state_d[i] = ACTIVE;
        end
        default: state_d[i] = state_q[i];
      endcase
    end
  end

  // Address decode; size inputs are used live.
  always_comb begin
    case (fastram_config)
      2'b01:   z2_mask = 4'b1110;
      2'b10:   z2_mask = 4'b1100;
      2'b11:   z2_mask = 4'b1000;
      default: z2_mask = 4'b0000;
    endcase
    z3b2_mask = (slowram_config != 2'b00) ? 12'hFF0 : 12'hFFC;

    for (int i = 0; i < 3; i++) act[i] = (state_q[i] == ACTIVE);

    // Base bits below the size alignment are masked out of the compare.
    hit[0] = (fastram_config != 2'b00) && (cpu_addr[31:24] == 8'h00) &&
             (((cpu_addr[23:20] ^ base_q[0][7:4]) & z2_mask) == 4'b0000);
    hit[1] = (((cpu_addr ^ {base_q[1], 4'h0}) & Z3B1_MASK) == 12'h000);
    hit[2] = (((cpu_addr ^ {base_q[2], 4'h0}) & z3b2_mask) == 12'h000);

    ram_sel_d = 3'b000;
    if (cpu_req) begin
      // Overlapping windows resolve to the lowest-index board.
      if (hit[0] && act[0])      ram_sel_d = 3'b001;
      else if (hit[1] && act[1]) ram_sel_d = 3'b010;
      else if (hit[2] && act[2]) ram_sel_d = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) state_q[i] <= UNCONF;
      base_q      <= '0;
      bc_q        <= '0;
      ram_sel_q   <= '0;
      ram_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) state_q[i] <= state_d[i];
      base_q      <= base_d;
      bc_q        <= board_configured[2:0];
      ram_sel_q   <= ram_sel_d;
      ram_valid_q <= cpu_req;
    end
  end

  assign ram_sel   = ram_sel_q;
  assign ram_valid = ram_valid_q;
  always_comb begin
    for (int i = 0; i < 3; i++) map_active[i] = (state_q[i] == ACTIVE);
  end

endmodule

// File: tb/tb_minimig_zorro_mapper.sv
module tb_minimig_zorro_mapper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk7_en, sel, hwr, lwr, cpu_req;
  logic [8:1]  address_in;
  logic [15:0] data_in;
  logic [1:0]  fastram_config, slowram_config;
  logic [3:0]  board_configured;
  logic [31:20] cpu_addr;
  logic [2:0]  ram_sel, map_active;
  logic        ram_valid;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] A_4A = 8'h25;
  localparam logic [7:0] A_48 = 8'h24;
  localparam logic [7:0] A_44 = 8'h22;
  localparam logic [7:0] A_4C = 8'h26;

  minimig_zorro_mapper #(.ZIII0_LOG2(24)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .sel(sel),
    .address_in(address_in), .data_in(data_in), .hwr(hwr), .lwr(lwr),
    .fastram_config(fastram_config), .slowram_config(slowram_config),
    .board_configured(board_configured), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
    .ram_sel(ram_sel), .ram_valid(ram_valid), .map_active(map_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic acwr(input logic [7:0] a, input logic [15:0] d, input logic low);
    address_in = a; data_in = d; clk7_en = 1'b1; sel = 1'b1;
    hwr = !low; lwr = low;
    tick();
    clk7_en = 1'b0; sel = 1'b0; hwr = 1'b0; lwr = 1'b0;
  endtask

  task automatic look(input string tag, input logic [11:0] a, input logic [2:0] exp);
    cpu_addr = a; cpu_req = 1'b1;
    tick();
    chk(tag, ram_sel, exp);
    chk({tag, "_valid"}, {2'b00, ram_valid}, 3'b001);
    cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; board_configured = 4'b0000; cpu_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; clk7_en = 1'b0; sel = 1'b0; hwr = 1'b0; lwr = 1'b0;
    address_in = '0; data_in = '0; fastram_config = 2'b00; slowram_config = 2'b00;
    board_configured = 4'b0000; cpu_addr = '0; cpu_req = 1'b0;
    #3;
    chk("rst_ram_sel", ram_sel, 3'b000);
    chk("rst_ram_valid", {2'b00, ram_valid}, 3'b000);
    chk("rst_map", map_active, 3'b000);
    tick();
    reset_n = 1'b1;
    tick();

    // Qualified-out writes must not stage; an edge then shuts board 0 up.
    fastram_config = 2'b10;
    address_in = A_48; data_in = 16'h2000; hwr = 1'b1; sel = 1'b1; clk7_en = 1'b0;
    tick();
    sel = 1'b0; clk7_en = 1'b1;
    tick();
    clk7_en = 1'b0; hwr = 1'b0;
    board_configured = 4'b0001;
    tick();
    chk("noqual_map", map_active, 3'b000);
    look("noqual_hit", 12'h003, 3'b000);
    do_reset();

    // Zorro II board, 4 MB at base nibble 2 (aligned window 0..3 MB).
    fastram_config = 2'b10;
    acwr(A_4A, 16'h0000, 1'b0);
    acwr(A_48, 16'h2000, 1'b1);
    chk("z2_staged_map", map_active, 3'b000);
    board_configured = 4'b0001;
    tick();
    chk("z2_active_map", map_active, 3'b001);
    look("z2_hit3", 12'h003, 3'b001);
    look("z2_hit0", 12'h000, 3'b001);
    look("z2_miss4", 12'h004, 3'b000);
    look("z2_miss_hi", 12'h103, 3'b000);
    cpu_addr = 12'h003; cpu_req = 1'b0;
    tick();
    chk("noreq_sel", ram_sel, 3'b000);
    chk("noreq_valid", {2'b00, ram_valid}, 3'b000);
    fastram_config = 2'b11;
    look("z2_8mb_hit7", 12'h007, 3'b001);
    fastram_config = 2'b01;
    look("z2_2mb_miss1", 12'h001, 3'b000);
    look("z2_2mb_hit2", 12'h002, 3'b001);
    fastram_config = 2'b00;
    look("z2_off", 12'h003, 3'b000);
    chk("z2_off_map", map_active, 3'b001);
    fastram_config = 2'b10;

    // Zorro III chain; board 2 base overwritten while staged.
    acwr(A_44, 16'h4000, 1'b0);
    board_configured = 4'b0011;
    tick();
    chk("z3b1_map", map_active, 3'b011);
    acwr(A_44, 16'h5000, 1'b0);
    acwr(A_44, 16'h4100, 1'b0);
    slowram_config = 2'b00;
    board_configured = 4'b0111;
    tick();
    chk("z3b2_map", map_active, 3'b111);
    look("z3_40F", 12'h40F, 3'b010);
    look("z3_400", 12'h400, 3'b010);
    look("z3_413", 12'h413, 3'b100);
    look("z3_414", 12'h414, 3'b000);
    look("z3_old_base", 12'h503, 3'b000);
    look("z2_still", 12'h003, 3'b001);
    slowram_config = 2'b01;
    look("z3b2_16mb", 12'h41F, 3'b100);
    acwr(A_4A, 16'hF000, 1'b0);
    acwr(A_48, 16'hF000, 1'b0);
    acwr(A_44, 16'h7000, 1'b0);
    look("active_ignore", 12'h003, 3'b001);
    chk("active_ignore_map", map_active, 3'b111);
    do_reset();

    // Shut-up of pending ZII, then ZIII base written in the edge cycle.
    fastram_config = 2'b10;
    acwr(A_4A, 16'h0000, 1'b0);
    acwr(A_48, 16'h0000, 1'b0);
    acwr(A_4C, 16'h0000, 1'b0);
    board_configured = 4'b0001;
    tick();
    chk("shut_map", map_active, 3'b000);
    look("shut_nohit", 12'h003, 3'b000);
    board_configured = 4'b0011;
    acwr(A_44, 16'h0000, 1'b0);
    chk("same_cycle_map", map_active, 3'b010);
    look("same_cycle_hit", 12'h003, 3'b010);
    do_reset();

    // Overlap priority, then reset with board 2 staged.
    fastram_config = 2'b10;
    acwr(A_48, 16'h0000, 1'b0);
    board_configured = 4'b0001;
    tick();
    acwr(A_44, 16'h0000, 1'b0);
    board_configured = 4'b0011;
    tick();
    chk("ovl_map", map_active, 3'b011);
    look("ovl_low", 12'h001, 3'b001);
    look("ovl_z3only", 12'h005, 3'b010);
    acwr(A_44, 16'h4000, 1'b0);
    chk("b2_staged_map", map_active, 3'b011);
    cpu_addr = 12'h001; cpu_req = 1'b1;
    tick();
    chk("pre_rst_sel", ram_sel, 3'b001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sel", ram_sel, 3'b000);
    chk("async_rst_valid", {2'b00, ram_valid}, 3'b000);
    chk("async_rst_map", map_active, 3'b000);
    board_configured = 4'b0000; cpu_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    board_configured = 4'b0100;
    tick();
    chk("rst_discard_map", map_active, 3'b000);
    look("rst_discard_hit", 12'h400, 3'b000);
    board_configured = 4'b0111;
    tick();
    chk("unconf_edge_map", map_active, 3'b000);
    look("unconf_edge_hit", 12'h001, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
